crtc_bus_master: RTL and testbench

Synthesisable, parametrised bus master that performs MC6845-style CPU register accesses (CSn/E/RS/RW/D) from a simple valid/ready command interface. Each access is an address-register write followed by a data-register write or read. E strobe widths are programmable in CLK cycles. An optional address cache skips the address phase when the target register is unchanged. It sits between init/control logic and the MC6845 core, replacing bench-only register tasks with hardware that can bring up the CRTC at power-on.

---
 rtl/crtc_bus_master.sv | 210 +++++++++++++++++++++
 tb/tb_crtc_bus_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_bus_master.sv
// MC6845 CPU-port bus master: turns valid/ready commands into address/data register cycles.
// Latency: 2*(E_HIGH+E_LOW) cycles per full access, E_HIGH+E_LOW when the address phase is skipped.
// Backpressure: cmd_ready is high only in IDLE; read data comes back as a one-cycle rsp_valid pulse.
module crtc_bus_master #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int E_HIGH    = 1,
  parameter int E_LOW     = 1,
  parameter bit SKIP_ADDR = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              CSn,
  output logic              E,
  output logic              RS,
  output logic              RW,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in
);

  localparam int E_MAX = (E_HIGH > E_LOW) ? E_HIGH : E_LOW;
  localparam int CNT_W = $clog2(E_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(E_HIGH);
  localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(E_LOW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA_HI,
    S_DATA_LO
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic              cache_vld_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic              cache_hit;
  logic              hi_done;
  logic              lo_done;
  logic              cache_load;
  logic              rd_capture;
  logic              rsp_fire;
  logic [DATA_W-1:0] addr_ext;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Compare against the live command: it is the value latched on this same edge.
  assign cache_hit = SKIP_ADDR && cache_vld_q && (cmd_addr == cache_addr_q);

  assign hi_done    = (cnt_q == CNT_HI);
  assign lo_done    = (cnt_q == CNT_LO);
  assign cache_load = (state_q == S_ADDR_HI) && hi_done;
  // D_in is sampled on the edge where E falls, while the CRTC still drives it.
  assign rd_capture = (state_q == S_DATA_HI) && hi_done && rw_q;
  assign rsp_fire   = (state_q == S_DATA_LO) && lo_done && rw_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State and phase counter registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each phase state lasts until the counter reaches its programmed width.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = cache_hit ? S_DATA_HI : S_ADDR_HI;
          cnt_d   = CNT_ONE;
        end
      end
      S_ADDR_HI: begin
        if (hi_done) begin
          state_d = S_ADDR_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ADDR_LO: begin
        if (lo_done) begin
          state_d = S_DATA_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA_HI: begin
        if (hi_done) begin
          state_d = S_DATA_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA_LO: begin
        if (lo_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Zero-extend the register address onto the data bus.
  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = addr_q;
  end

  // Bus outputs decoded from state so reset returns the bus to idle immediately.
  always_comb begin
    CSn   = 1'b1;
    E     = 1'b0;
    RS    = 1'b0;
    RW    = 1'b1;
    D_oe  = 1'b0;
    D_out = '0;
    case (state_q)
      S_ADDR_HI, S_ADDR_LO: begin
        CSn   = 1'b0;
        E     = (state_q == S_ADDR_HI);
        RS    = 1'b0;
        RW    = 1'b0;
        D_oe  = 1'b1;
        D_out = addr_ext;
      end
      S_DATA_HI, S_DATA_LO: begin
        CSn   = 1'b0;
        E     = (state_q == S_DATA_HI);
        RS    = 1'b1;
        RW    = rw_q;
        D_oe  = !rw_q;
        D_out = rw_q ? '0 : wdata_q;
      end
      default: begin
        CSn = 1'b1;
      end
    endcase
  end

  // Command latch, address cache, read capture and response registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rw_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      if (accept) begin
        rw_q    <= cmd_rw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (cache_load) begin
        cache_addr_q <= addr_q;
        cache_vld_q  <= 1'b1;
      end
      if (rd_capture) begin
        rdata_q <= D_in;
      end
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_rdata_q <= rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_crtc_bus_master.sv
// Directed bench for crtc_bus_master: a default instance (E 1/1, address skip on)
// and a slow instance (E 3/2, address skip off) share one command port selected by sel.
// A small CRTC model answers reads with dev_rd only while E is high on a data-register read.
module tb_crtc_bus_master;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       sel;
  logic       cmd_valid;
  logic       cmd_rw;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] dev_rd;

  logic       f_cmd_valid, f_ready, f_rsp, f_busy, f_csn, f_e, f_rs, f_rw, f_oe;
  logic [7:0] f_rdata, f_dout, f_din;
  logic       s_cmd_valid, s_ready, s_rsp, s_busy, s_csn, s_e, s_rs, s_rw, s_oe;
  logic [7:0] s_rdata, s_dout, s_din;

  logic        m_ready, m_busy, m_rsp, m_e, m_rs;
  logic [7:0]  m_rdata, m_dout;
  logic [13:0] m_bus;

  always #5 CLK = ~CLK;

  assign f_cmd_valid = cmd_valid && !sel;
  assign s_cmd_valid = cmd_valid && sel;
  assign f_din = (!f_csn && f_e && f_rs && f_rw) ? dev_rd : 8'hA5;
  assign s_din = (!s_csn && s_e && s_rs && s_rw) ? dev_rd : 8'hA5;

  assign m_ready = sel ? s_ready : f_ready;
  assign m_busy  = sel ? s_busy  : f_busy;
  assign m_rsp   = sel ? s_rsp   : f_rsp;
  assign m_rdata = sel ? s_rdata : f_rdata;
  assign m_e     = sel ? s_e     : f_e;
  assign m_rs    = sel ? s_rs    : f_rs;
  assign m_dout  = sel ? s_dout  : f_dout;
  assign m_bus   = sel ? {s_csn, s_e, s_rs, s_rw, s_oe, s_rsp, s_dout}
                       : {f_csn, f_e, f_rs, f_rw, f_oe, f_rsp, f_dout};

  crtc_bus_master #(.ADDR_W(5), .DATA_W(8), .E_HIGH(1), .E_LOW(1), .SKIP_ADDR(1'b1)) u_fast (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(f_cmd_valid), .cmd_ready(f_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(f_rsp), .rsp_rdata(f_rdata),
    .busy(f_busy), .CSn(f_csn), .E(f_e), .RS(f_rs), .RW(f_rw), .D_out(f_dout),
    .D_oe(f_oe), .D_in(f_din)
  );

  crtc_bus_master #(.ADDR_W(5), .DATA_W(8), .E_HIGH(3), .E_LOW(2), .SKIP_ADDR(1'b0)) u_slow (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(s_cmd_valid), .cmd_ready(s_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(s_rsp), .rsp_rdata(s_rdata),
    .busy(s_busy), .CSn(s_csn), .E(s_e), .RS(s_rs), .RW(s_rw), .D_out(s_dout),
    .D_oe(s_oe), .D_in(s_din)
  );

  typedef struct {
    logic       sel;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] dev;
    logic       exp_skip;
    int         exp_busy;
    logic       exp_rsp;
    logic [7:0] exp_rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] exp_bus(input logic csn, input logic e, input logic rs,
                                          input logic rw, input logic oe, input logic rv,
                                          input logic [7:0] d);
    return {csn, e, rs, rw, oe, rv, d};
  endfunction

  // Issue one command, follow it cycle by cycle and check the returned idle/response state.
  task automatic run_vec(input vec_t v);
    int          eh, el, idx, nb;
    bit          ok, in_addr, ph_hi;
    logic [13:0] e_bus;
    eh = v.sel ? 3 : 1;
    el = v.sel ? 2 : 1;
    sel       = v.sel;
    cmd_rw    = v.rw;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    dev_rd    = v.dev;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_ready", {31'd0, ok}, 32'd1);
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    cmd_rw    = ~v.rw;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    nb = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (!m_busy) break;
      nb++;
      idx = c - 1;
      in_addr = 1'b0;
      if (!v.exp_skip) begin
        if (idx < eh + el) in_addr = 1'b1;
        else idx -= eh + el;
      end
      ph_hi = (idx < eh);
      if (in_addr) e_bus = exp_bus(1'b0, ph_hi, 1'b0, 1'b0, 1'b1, 1'b0, {3'b000, v.addr});
      else         e_bus = exp_bus(1'b0, ph_hi, 1'b1, v.rw, !v.rw, 1'b0,
                                   v.rw ? 8'h00 : v.wdata);
      check($sformatf("bus_cycle%0d", c), {18'd0, m_bus}, {18'd0, e_bus});
    end
    check("busy_len", nb, v.exp_busy);
    check("idle_bus", {18'd0, m_bus}, {18'd0, exp_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, v.exp_rsp, 8'h00)});
    check("idle_ready_busy", {30'd0, m_ready, m_busy}, 32'd2);
    check("rsp_rdata", {24'd0, m_rdata}, {24'd0, v.exp_rdata});
    @(negedge CLK);
    check("rsp_pulse_end", {31'd0, m_rsp}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[10];
    vec_t       v_after;
    int         n_acc, nb, gaps, nd;
    bit         ok, rsp_seen;
    logic [7:0] dseen[3];

    // sel rw addr   wdata  dev    skip busy rsp rdata
    tbl[0] = '{1'b0, 1'b0, 5'h00, 8'h5E, 8'h00, 1'b0, 4,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 5'h0E, 8'h33, 8'h00, 1'b0, 4,  1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 5'h0E, 8'h00, 8'hFA, 1'b1, 2,  1'b1, 8'hFA};
    tbl[3] = '{1'b0, 1'b1, 5'h0E, 8'h00, 8'h12, 1'b1, 2,  1'b1, 8'h12};
    tbl[4] = '{1'b0, 1'b1, 5'h01, 8'h00, 8'h3C, 1'b0, 4,  1'b1, 8'h3C};
    tbl[5] = '{1'b0, 1'b0, 5'h01, 8'h77, 8'h00, 1'b1, 2,  1'b0, 8'h3C};
    tbl[6] = '{1'b0, 1'b0, 5'h1F, 8'hC0, 8'h00, 1'b0, 4,  1'b0, 8'h3C};
    tbl[7] = '{1'b1, 1'b0, 5'h0C, 8'h40, 8'h00, 1'b0, 10, 1'b0, 8'h00};
    tbl[8] = '{1'b1, 1'b1, 5'h0E, 8'h00, 8'hFA, 1'b0, 10, 1'b1, 8'hFA};
    tbl[9] = '{1'b1, 1'b1, 5'h0E, 8'h00, 8'h81, 1'b0, 10, 1'b1, 8'h81};

    RSTn = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_addr = 5'h00; cmd_wdata = 8'h00; dev_rd = 8'h00;

    // Reset state of both instances.
    @(negedge CLK);
    @(negedge CLK);
    check("rst_fast_bus", {18'd0, m_bus}, {18'd0, exp_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)});
    check("rst_fast_status", {22'd0, m_ready, m_busy, m_rdata}, {22'd0, 1'b1, 1'b0, 8'h00});
    sel = 1'b1;
    #1;
    check("rst_slow_bus", {18'd0, m_bus}, {18'd0, exp_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)});
    check("rst_slow_status", {22'd0, m_ready, m_busy, m_rdata}, {22'd0, 1'b1, 1'b0, 8'h00});
    sel = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // cmd_valid held high across three writes to one register.
    sel = 1'b0; cmd_rw = 1'b0; cmd_addr = 5'h02; cmd_wdata = 8'h11;
    n_acc = 0; nb = 0; gaps = 0; nd = 0; rsp_seen = 1'b0;
    dseen[0] = 8'h00; dseen[1] = 8'h00; dseen[2] = 8'h00;
    cmd_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (m_rsp) rsp_seen = 1'b1;
      if (m_busy) begin
        nb++;
        if (m_e && m_rs && nd < 3) begin
          dseen[nd] = m_dout;
          nd++;
        end
      end else if (cmd_valid && n_acc > 0) begin
        gaps++;
      end
      if (cmd_valid && m_ready) begin
        n_acc++;
        @(posedge CLK);
        #1;
        if (n_acc == 1)      cmd_wdata = 8'h22;
        else if (n_acc == 2) cmd_wdata = 8'h33;
        else                 cmd_valid = 1'b0;
      end
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    check("held_accepts", n_acc, 3);
    check("held_busy_cycles", nb, 8);
    check("held_idle_gaps", gaps, 2);
    check("held_data0", {24'd0, dseen[0]}, 32'h11);
    check("held_data1", {24'd0, dseen[1]}, 32'h22);
    check("held_data2", {24'd0, dseen[2]}, 32'h33);
    check("held_no_rsp", {31'd0, rsp_seen}, 32'd0);

    // Reset asserted during DATA_HI of a read.
    sel = 1'b0; cmd_rw = 1'b1; cmd_addr = 5'h05; cmd_wdata = 8'h00; dev_rd = 8'h99;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (m_busy && m_e && m_rs) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_data_hi", {31'd0, ok}, 32'd1);
    RSTn = 1'b0;
    #1;
    check("rst_mid_bus", {18'd0, m_bus}, {18'd0, exp_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)});
    check("rst_mid_status", {22'd0, m_ready, m_busy, m_rdata}, {22'd0, 1'b1, 1'b0, 8'h00});
    cmd_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_no_accept", {31'd0, m_busy}, 32'd0);
    cmd_valid = 1'b0;
    RSTn = 1'b1;
    rsp_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (m_rsp) rsp_seen = 1'b1;
    end
    check("rst_no_rsp", {31'd0, rsp_seen}, 32'd0);
    v_after = '{1'b0, 1'b1, 5'h05, 8'h00, 8'h99, 1'b0, 4, 1'b1, 8'h99};
    run_vec(v_after);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
